// File: rtl/aes_round_ctrl.sv
// Sequencer for an iterative AES-128 encryption datapath: initial AddRoundKey,
// then NR passes through the external round function, fetching one round key per pass.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         rk_req,
  output logic [3:0]   rk_idx,
  input  logic         rk_valid,
  input  logic [127:0] rk_data,
  output logic [127:0] dp_state,
  output logic [127:0] dp_key,
  output logic         dp_last,
  input  logic [127:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic [3:0]   round
);

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEY   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   r_q, r_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      key_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      key_q   <= key_d;
      r_q     <= r_d;
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready (or req)
  // are both high; the producer holds valid/data stable until that edge.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = in_block;
          r_d     = '0;
          state_d = KEY;
        end
      end
      KEY: begin
        if (rk_valid) begin
          // Key 0 is folded straight into the state; later keys feed the datapath.
          if (r_q == 4'd0) begin
            st_d = st_q ^ rk_data;
            r_d  = 4'd1;
          end else begin
            key_d   = rk_data;
            state_d = ROUND;
          end
        end
      end
      ROUND: begin
        st_d = dp_result;
        if (r_q == NR_L) begin
          state_d = DONE;
        end else begin
          r_d     = r_q + 4'd1;
          state_d = KEY;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control outputs are forced low while reset is asserted.
  always_comb begin
    in_ready  = !rst && (state_q == IDLE);
    rk_req    = !rst && (state_q == KEY);
    out_valid = !rst && (state_q == DONE);
    dp_last   = !rst && (state_q == ROUND) && (r_q == NR_L);
    rk_idx    = r_q;
    dp_state  = st_q;
    dp_key    = key_q;
    out_block = st_q;
    round     = r_q;
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: an AES-128 model supplies the round datapath and key
// schedule, and predicts ciphertext and latency for directed and random blocks.
module tb_aes_round_ctrl;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic [127:0] dp_state;
  logic [127:0] dp_key;
  logic         dp_last;
  logic [127:0] dp_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic [3:0]   round;

  aes_round_ctrl #(.NR(NR)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .rk_req(rk_req), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_data(rk_data),
    .dp_state(dp_state), .dp_key(dp_key), .dp_last(dp_last), .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .round(round)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]        sbox [256];
  logic [11*128-1:0] rk_flat;
  int                rk_delay;
  int                rk_wait;
  logic              rk_inject;
  logic [127:0]      rk_junk;
  logic [3:0]        idx_q [$];

  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  // ---------------- AES reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Byte i of a block is column i/4, row i%4 (FIPS-197 input order).
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[c*4+r] = b[((c + r) % 4)*4 + r];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[c*4]; a1 = t[c*4+1]; a2 = t[c*4+2]; a3 = t[c*4+3];
        t[c*4]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[c*4+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[c*4+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[c*4+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  function automatic logic [11*128-1:0] key_expand(input logic [127:0] key);
    logic [31:0]       w [44];
    logic [31:0]       tmp;
    logic [7:0]        rc = 8'h01;
    logic [11*128-1:0] f;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 11; j++) f[j*128 +: 128] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return f;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [11*128-1:0] f = key_expand(key);
    logic [127:0]      s = pt ^ f[127:0];
    for (int r = 1; r <= NR; r++) s = aes_round(s, f[r*128 +: 128], r == NR);
    return s;
  endfunction

  // ---------------- environment: datapath and key-expansion responder ----------------
  assign dp_result = aes_round(dp_state, dp_key, dp_last);
  assign rk_valid  = (rk_req && (rk_wait >= rk_delay)) || rk_inject;
  assign rk_data   = rk_inject ? rk_junk : rk_flat[int'(rk_idx)*128 +: 128];

  always @(posedge clk) begin
    if (rk_req && rk_valid) begin
      idx_q.push_back(rk_idx);
      rk_wait <= 0;
    end else if (rk_req) begin
      rk_wait <= rk_wait + 1;
    end else begin
      rk_wait <= 0;
    end
  end

  // ---------------- checking and drivers ----------------
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present a block and return just after the accepting edge.
  task automatic send(input logic [127:0] pt, input bit keep);
    int w = 0;
    idx_q.delete();
    in_valid = 1'b1;
    in_block = pt;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq("accept_wait", 128'(w < 100), 128'd1);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  // Wait for the result, check it, optionally stall in DONE, then take it.
  task automatic collect(input logic [127:0] exp_ct, input int exp_lat, input int stall,
                         input bit inject);
    int           cyc = 0;
    logic [127:0] hold_blk, hold_key;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 300);
    check_eq("latency", 128'(cyc), 128'(exp_lat));
    check_eq("ciphertext", out_block, exp_ct);
    check_eq("rk_count", 128'(idx_q.size()), 128'(NR + 1));
    for (int i = 0; i <= NR; i++)
      if (i < idx_q.size()) check_eq("rk_idx_seq", 128'(idx_q[i]), 128'(i));
    hold_blk = out_block;
    hold_key = dp_key;
    for (int s = 0; s < stall; s++) begin
      rk_inject = inject;
      rk_junk   = rand128();
      @(posedge clk);
      #1 rk_inject = 1'b0;
      @(negedge clk);
      check_eq("stall_out_valid", 128'(out_valid), 128'd1);
      check_eq("stall_out_block", out_block, hold_blk);
      check_eq("stall_dp_key", dp_key, hold_key);
      check_eq("stall_in_ready", 128'(in_ready), 128'd0);
      check_eq("stall_rk_req", 128'(rk_req), 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_eq("idle_in_ready", 128'(in_ready), 128'd1);
    check_eq("idle_out_valid", 128'(out_valid), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt, key, held_st, held_key;
    int           d, stall;
    bit           saw_out;

    build_sbox();
    rst = 1'b1; in_valid = 1'b0; in_block = '0; out_ready = 1'b0;
    rk_delay = 0; rk_inject = 1'b0; rk_junk = '0; rk_flat = '0;

    @(negedge clk);
    check_eq("rst_in_ready", 128'(in_ready), 128'd0);
    check_eq("rst_rk_req", 128'(rk_req), 128'd0);
    check_eq("rst_out_valid", 128'(out_valid), 128'd0);
    check_eq("rst_dp_last", 128'(dp_last), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_in_ready", 128'(in_ready), 128'd1);
    check_eq("reset_round", 128'(round), 128'd0);
    check_eq("reset_dp_state", dp_state, 128'd0);
    check_eq("reset_dp_key", dp_key, 128'd0);

    check_eq("model_fips", aes_encrypt(FIPS_PT, FIPS_KEY), FIPS_CT);
    check_eq("model_zero", aes_encrypt(128'd0, 128'd0), ZERO_CT);

    // FIPS vector, zero-wait keys
    rk_flat = key_expand(FIPS_KEY);
    rk_delay = 0;
    send(FIPS_PT, 1'b0);
    collect(FIPS_CT, 2*NR + 2, 0, 1'b0);

    // Key responses delayed 3 cycles each
    rk_delay = 3;
    send(FIPS_PT, 1'b0);
    collect(FIPS_CT, 2*NR + 2 + 3*(NR + 1), 0, 1'b0);

    // Back-pressure in DONE with stray rk_valid pulses
    rk_delay = 0;
    send(FIPS_PT, 1'b0);
    collect(FIPS_CT, 2*NR + 2, 5, 1'b1);

    // Stray rk_valid while idle must not disturb anything
    held_st  = dp_state;
    held_key = dp_key;
    for (int i = 0; i < 3; i++) begin
      rk_inject = 1'b1;
      rk_junk   = rand128();
      @(posedge clk);
      #1 rk_inject = 1'b0;
      @(negedge clk);
    end
    check_eq("idle_inject_state", dp_state, held_st);
    check_eq("idle_inject_key", dp_key, held_key);
    check_eq("idle_inject_ready", 128'(in_ready), 128'd1);

    // Reset pulse while in ROUND r=5
    send(FIPS_PT, 1'b0);
    repeat (11) @(negedge clk);
    check_eq("pre_rst_round", 128'(round), 128'd5);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_in_ready", 128'(in_ready), 128'd0);
    check_eq("mid_rst_dp_last", 128'(dp_last), 128'd0);
    check_eq("mid_rst_rk_req", 128'(rk_req), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 128'(in_ready), 128'd1);
    check_eq("post_rst_rk_req", 128'(rk_req), 128'd0);
    check_eq("post_rst_round", 128'(round), 128'd0);
    check_eq("post_rst_dp_state", dp_state, 128'd0);
    rk_inject = 1'b1;
    rk_junk   = rand128();
    @(posedge clk);
    #1 rk_inject = 1'b0;
    saw_out = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) saw_out = 1'b1;
    end
    check_eq("post_rst_no_out", 128'(saw_out), 128'd0);
    check_eq("late_rk_state", dp_state, 128'd0);
    check_eq("late_rk_key", dp_key, 128'd0);
    send(FIPS_PT, 1'b0);
    collect(FIPS_CT, 2*NR + 2, 0, 1'b0);

    // Two blocks back to back with in_valid held high
    send(FIPS_PT, 1'b1);
    in_block = 128'd0;
    collect(FIPS_CT, 2*NR + 2, 0, 1'b0);
    rk_flat = key_expand(128'd0);
    send(128'd0, 1'b0);
    collect(ZERO_CT, 2*NR + 2, 0, 1'b0);

    // Random blocks, key latencies and back-pressure
    for (int n = 0; n < 8; n++) begin
      pt       = rand128();
      key      = rand128();
      d        = $urandom_range(0, 3);
      stall    = $urandom_range(0, 4);
      rk_delay = d;
      rk_flat  = key_expand(key);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(pt, 1'b0);
      collect(aes_encrypt(pt, key), 2*NR + 2 + d*(NR + 1), stall, 1'(n % 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
